// File: rtl/div_issue.sv
// Issue/release controller between the EX stage and a multi-cycle divider; owns operand capture, stall and HI/LO write.
// Optional macro DIV_ISSUE_ZERO_BYPASS_EN: divide-by-zero skips the divider and writes {0,0} one cycle after issue.
module div_issue #(
  localparam int unsigned DATA_W = 32
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EX_DIV_REQ,
  input  logic                EX_DIV_SIGNED,
  input  logic [DATA_W-1:0]   EX_OP1,
  input  logic [DATA_W-1:0]   EX_OP2,
  input  logic                FLUSH,
  output logic                DIV_START,
  output logic                DIV_CANCEL,
  output logic                DIV_SIGNED,
  output logic [DATA_W-1:0]   DIV_DIVIDEND,
  output logic [DATA_W-1:0]   DIV_DIVISOR,
  input  logic                DIV_READY,
  input  logic [2*DATA_W-1:0] DIV_RESULT,
  output logic                STALL_REQ,
  output logic                HILO_WE,
  output logic [DATA_W-1:0]   HI_DATA,
  output logic [DATA_W-1:0]   LO_DATA
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
`ifdef DIV_ISSUE_ZERO_BYPASS_EN
    ,
    ST_ZERO    = 2'd3
`endif
  } state_t;

  typedef struct packed {
    logic              sgn;
    logic [DATA_W-1:0] dividend;
    logic [DATA_W-1:0] divisor;
  } operands_t;

  state_t    state_q, state_d;
  operands_t op_q, op_d;
  logic      take_result;

  // State and operand registers; reset abandons any divide in flight.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Next state and all control outputs.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    DIV_START   = 1'b0;
    DIV_CANCEL  = 1'b0;
    HILO_WE     = 1'b0;
    STALL_REQ   = 1'b0;
    take_result = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (EX_DIV_REQ && !FLUSH) begin
          STALL_REQ = 1'b1;
          op_d      = '{sgn: EX_DIV_SIGNED, dividend: EX_OP1, divisor: EX_OP2};
`ifdef DIV_ISSUE_ZERO_BYPASS_EN
          state_d   = (EX_OP2 == '0) ? ST_ZERO : ST_BUSY;
`else
          state_d   = ST_BUSY;
`endif
        end
      end
      ST_BUSY: begin
        STALL_REQ = !DIV_READY;
        if (FLUSH) begin
          // Flush beats a same-cycle READY: the result is dropped.
          DIV_CANCEL = 1'b1;
          state_d    = ST_RELEASE;
        end else begin
          DIV_START = 1'b1;
          if (DIV_READY) begin
            HILO_WE     = 1'b1;
            take_result = 1'b1;
            state_d     = ST_RELEASE;
          end
        end
      end
      ST_RELEASE: begin
        // START low for one cycle lets the divider drop out of DONE.
        STALL_REQ = EX_DIV_REQ;
        state_d   = ST_IDLE;
      end
`ifdef DIV_ISSUE_ZERO_BYPASS_EN
      ST_ZERO: begin
        HILO_WE = 1'b1;
        state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  assign DIV_SIGNED   = op_q.sgn;
  assign DIV_DIVIDEND = op_q.dividend;
  assign DIV_DIVISOR  = op_q.divisor;

  // HI/LO carry data only on a divider write; zero otherwise (including bypass).
  assign HI_DATA = take_result ? DIV_RESULT[2*DATA_W-1:DATA_W] : '0;
  assign LO_DATA = take_result ? DIV_RESULT[DATA_W-1:0]        : '0;

endmodule

// File: tb/tb_div_issue.sv
// Bench for div_issue: behavioural divider responder plus arithmetic reference for timing and HI/LO values.
module tb_div_issue;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        EX_DIV_REQ = 1'b0;
  logic        EX_DIV_SIGNED = 1'b0;
  logic [31:0] EX_OP1 = '0;
  logic [31:0] EX_OP2 = '0;
  logic        FLUSH = 1'b0;
  logic        DIV_START, DIV_CANCEL, DIV_SIGNED;
  logic [31:0] DIV_DIVIDEND, DIV_DIVISOR;
  logic        DIV_READY;
  logic [63:0] DIV_RESULT;
  logic        STALL_REQ, HILO_WE;
  logic [31:0] HI_DATA, LO_DATA;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  div_issue dut (
    .CLK(CLK), .RST(RST), .EX_DIV_REQ(EX_DIV_REQ), .EX_DIV_SIGNED(EX_DIV_SIGNED),
    .EX_OP1(EX_OP1), .EX_OP2(EX_OP2), .FLUSH(FLUSH),
    .DIV_START(DIV_START), .DIV_CANCEL(DIV_CANCEL), .DIV_SIGNED(DIV_SIGNED),
    .DIV_DIVIDEND(DIV_DIVIDEND), .DIV_DIVISOR(DIV_DIVISOR),
    .DIV_READY(DIV_READY), .DIV_RESULT(DIV_RESULT),
    .STALL_REQ(STALL_REQ), .HILO_WE(HILO_WE), .HI_DATA(HI_DATA), .LO_DATA(LO_DATA)
  );

  // Reference arithmetic: {remainder, quotient}, divide-by-zero gives {0,0}.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      q  = sa / sb;
      r  = sa % sb;
      return {32'(r), 32'(q)};
    end
    return {a % b, a / b};
  endfunction

  function automatic logic ref_bypass(input logic [31:0] b);
`ifdef DIV_ISSUE_ZERO_BYPASS_EN
    return b == 32'd0;
`else
    return 1'b0;
`endif
  endfunction

  // Cycles from issue to HI/LO write.
  function automatic int ref_lat(input logic [31:0] b);
    if (b != 32'd0) return 35;
    return ref_bypass(b) ? 1 : 3;
  endfunction

  function automatic logic [67:0] ev(input logic st, input logic sr, input logic cn,
                                     input logic we, input logic [63:0] r);
    return {st, sr, cn, we, (we ? r : 64'd0)};
  endfunction

  // Divider responder: 33 run cycles (1 for zero divisor), DONE held while START is high.
  logic [1:0]  dv_st = 2'd0;
  logic [5:0]  dv_cnt = '0;
  logic [63:0] dv_res = '0;
  always @(posedge CLK) begin
    if (!RST || DIV_CANCEL) dv_st <= 2'd0;
    else begin
      case (dv_st)
        2'd0: if (DIV_START) begin
          dv_st  <= 2'd1;
          dv_cnt <= (DIV_DIVISOR == 32'd0) ? 6'd0 : 6'd32;
        end
        2'd1: if (dv_cnt == 6'd0) begin
          dv_st  <= 2'd2;
          dv_res <= ref_div(DIV_SIGNED, DIV_DIVIDEND, DIV_DIVISOR);
        end else dv_cnt <= dv_cnt - 6'd1;
        default: if (!DIV_START) dv_st <= 2'd0;
      endcase
    end
  end
  assign DIV_READY  = (dv_st == 2'd2);
  assign DIV_RESULT = DIV_READY ? dv_res : 64'hA5A5_5A5A_C3C3_3C3C;

  function automatic logic [67:0] obs_v();
    return {STALL_REQ, DIV_START, DIV_CANCEL, HILO_WE, HI_DATA, LO_DATA};
  endfunction

  // One cycle: drive after the falling edge, leave settled values for sampling.
  task automatic drive(input logic req, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic fl, input logic rst);
    @(negedge CLK);
    EX_DIV_REQ = req; EX_DIV_SIGNED = sgn; EX_OP1 = a; EX_OP2 = b; FLUSH = fl; RST = rst;
    #2;
  endtask

  task automatic test_reset();
    logic [67:0] o;
    drive(1'b0, 1'b1, $urandom, $urandom, 1'b0, 1'b0);
    drive(1'b0, 1'b1, $urandom, $urandom, 1'b0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      o = obs_v();
      vectors++;
      if (o !== 68'd0) begin
        miscompares++;
        $display("FAIL reset_outputs cycle %0d: got %h expected 0", c, o);
      end
      vectors++;
      if ({DIV_SIGNED, DIV_DIVIDEND, DIV_DIVISOR} !== 65'd0) begin
        miscompares++;
        $display("FAIL reset_operands cycle %0d: got %h expected 0", c, {DIV_SIGNED, DIV_DIVIDEND, DIV_DIVISOR});
      end
      drive(1'b0, 1'b0, $urandom, $urandom, 1'b0, 1'b1);
    end
  endtask

  task automatic test_single_div(input string name, input logic s, input logic [31:0] a, input logic [31:0] b);
    int lat;
    logic byp;
    logic [63:0] res;
    logic [67:0] e, o;
    lat = ref_lat(b);
    byp = ref_bypass(b);
    res = ref_div(s, a, b);
    for (int c = 0; c <= lat + 2; c++) begin
      if (c == 0) drive(1'b1, s, a, b, 1'b0, 1'b1);
      else drive(c <= lat, 1'($urandom), $urandom, $urandom, 1'b0, 1'b1);
      e = ev(c < lat, !byp && c >= 1 && c <= lat, 1'b0, c == lat, res);
      o = obs_v();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, c, o, e);
      end
      if (!byp && c >= 1 && c <= lat) begin
        vectors++;
        if ({DIV_SIGNED, DIV_DIVIDEND, DIV_DIVISOR} !== {s, a, b}) begin
          miscompares++;
          $display("FAIL %s_operands cycle %0d: got %h expected %h", name, c,
                   {DIV_SIGNED, DIV_DIVIDEND, DIV_DIVISOR}, {s, a, b});
        end
      end
    end
  endtask

  task automatic test_flush();
    logic [67:0] e, o;
    // Flush in IDLE suppresses issue and stall.
    for (int c = 0; c < 2; c++) begin
      drive(c == 0, 1'b0, 32'd50, 32'd5, c == 0, 1'b1);
      e = ev(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
      o = obs_v();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL flush_idle cycle %0d: got %h expected %h", c, o, e);
      end
    end
    // Flush ten cycles into a divide.
    for (int c = 0; c <= 13; c++) begin
      drive(c <= 10, 1'b0, (c == 0) ? 32'd12345 : $urandom, (c == 0) ? 32'd3 : $urandom, c == 10, 1'b1);
      e = ev(c <= 10, c >= 1 && c <= 9, c == 10, 1'b0, 64'd0);
      o = obs_v();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL flush_busy cycle %0d: got %h expected %h", c, o, e);
      end
    end
    test_single_div("after_flush", 1'b0, 32'd100, 32'd7);
  endtask

  task automatic test_flush_ready();
    logic [67:0] e, o;
    for (int c = 0; c <= 37; c++) begin
      drive(c <= 35, 1'b1, (c == 0) ? 32'd999 : $urandom, (c == 0) ? 32'd4 : $urandom, c == 35, 1'b1);
      e = ev(c < 35, c >= 1 && c <= 34, c == 35, 1'b0, 64'd0);
      o = obs_v();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL flush_ready cycle %0d: got %h expected %h", c, o, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] r1, r2;
    logic [67:0] e, o;
    logic [31:0] a, b;
    int i2, w2;
    r1 = ref_div(1'b1, 32'd1000, 32'd3);
    r2 = ref_div(1'b1, 32'hFFFF_FF85, 32'd5);
    i2 = 37;
    w2 = i2 + ref_lat(32'd5);
    for (int c = 0; c <= w2 + 2; c++) begin
      a = $urandom; b = $urandom;
      if (c == 0) begin a = 32'd1000; b = 32'd3; end
      if (c == 36 || c == 37) begin a = 32'hFFFF_FF85; b = 32'd5; end
      drive(c <= w2, 1'b1, a, b, 1'b0, 1'b1);
      e = ev(c < 35 || (c >= 36 && c < w2),
             (c >= 1 && c <= 35) || (c > i2 && c <= w2),
             1'b0, c == 35 || c == w2, (c == 35) ? r1 : r2);
      o = obs_v();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL back_to_back cycle %0d: got %h expected %h", c, o, e);
      end
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [67:0] o;
    for (int c = 0; c <= 11; c++)
      drive(c <= 10, 1'b0, (c == 0) ? 32'd77 : $urandom, (c == 0) ? 32'd2 : $urandom, 1'b0, c != 11);
    for (int c = 12; c <= 45; c++) begin
      drive(1'b0, 1'b0, $urandom, $urandom, 1'b0, 1'b1);
      o = obs_v();
      vectors++;
      if (o !== 68'd0 || DIV_DIVIDEND !== 32'd0) begin
        miscompares++;
        $display("FAIL reset_mid_busy cycle %0d: got %h/%h expected 0", c, o, DIV_DIVIDEND);
      end
    end
  endtask

  task automatic test_random();
    logic s;
    logic [31:0] a, b;
    logic [67:0] o;
    for (int n = 0; n < 20; n++) begin
      s = 1'($urandom);
      a = $urandom;
      b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
      if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
      test_single_div("random", s, a, b);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        drive(1'b0, 1'($urandom), $urandom, $urandom, 1'($urandom), 1'b1);
        o = obs_v();
        vectors++;
        if (o !== 68'd0) begin
          miscompares++;
          $display("FAIL random_gap iter %0d: got %h expected 0", n, o);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_div("div_signed", 1'b1, 32'hFFFF_FFF9, 32'd2);
    test_single_div("divu", 1'b0, 32'hFFFF_FFFF, 32'h10);
    test_flush();
    test_flush_ready();
    test_back_to_back();
    test_single_div("div_by_zero", 1'b1, 32'd1234, 32'd0);
    test_reset_mid_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
